// File: rtl/rf_wb_pkg.sv
// Shared constants and types for the register-file write-back arbiter.
// Holds the address/data widths, FIFO geometry and the entry/port types
// used by wb_fifo2 and regfile_wb_arbiter.
package rf_wb_pkg;

    localparam int RF_ADDR_W     = 5;
    localparam int RF_DATA_W     = 32;
    localparam int WB_FIFO_DEPTH = 2;
    localparam int WB_PORTS      = 2;

    // Pointer and occupancy widths derived from the FIFO depth.
    localparam int WB_PTR_W = $clog2(WB_FIFO_DEPTH);
    localparam int WB_CNT_W = $clog2(WB_FIFO_DEPTH + 1);

    typedef logic [RF_ADDR_W-1:0] rf_addr_t;
    typedef logic [RF_DATA_W-1:0] rf_data_t;

    // One pending register write.
    typedef struct packed {
        rf_addr_t addr;
        rf_data_t data;
    } wb_entry_t;

    // Identifies a request port; also the encoding of the last-grant pointer.
    typedef enum logic {
        PORT0 = 1'b0,
        PORT1 = 1'b1
    } port_e;

    // True when a valid slot holds the queried register address.
    function automatic logic addr_match(input logic valid, input rf_addr_t slot_addr,
                                        input rf_addr_t query_addr);
        return valid && (slot_addr == query_addr);
    endfunction

endpackage

// File: rtl/wb_fifo2.sv
// Two-entry write-back FIFO for one request port.
// Circular buffer with read/write pointers and an occupancy counter.
// Exposes per-slot valid flags and addresses so the top level can check
// for pending writes to a queried register.
module wb_fifo2 import rf_wb_pkg::*; (
    input  logic                                Clk,
    input  logic                                Reset,
    input  logic                                push,
    input  wb_entry_t                           push_entry,
    input  logic                                pop,
    output logic                                full,
    output logic                                empty,
    output wb_entry_t                           head,
    output logic     [WB_FIFO_DEPTH-1:0]        entry_valid,
    output rf_addr_t [WB_FIFO_DEPTH-1:0]        entry_addr
);

    wb_entry_t [WB_FIFO_DEPTH-1:0] mem;
    logic      [WB_PTR_W-1:0]      rd_ptr;
    logic      [WB_PTR_W-1:0]      wr_ptr;
    logic      [WB_CNT_W-1:0]      count;

    logic push_en;
    logic pop_en;

    // A full FIFO refuses pushes even when it is popped in the same cycle.
    assign full    = (count == WB_CNT_W'(WB_FIFO_DEPTH));
    assign empty   = (count == '0);
    assign push_en = push && !full;
    assign pop_en  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge Clk or posedge Reset) begin
        // NOTE: sequential state uses non-blocking (<=) so every flop samples
        // pre-edge values regardless of statement order.
        if (Reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_en) wr_ptr <= wr_ptr + WB_PTR_W'(1);
            if (pop_en)  rd_ptr <= rd_ptr + WB_PTR_W'(1);
            case ({push_en, pop_en})
                2'b10:   count <= count + WB_CNT_W'(1);
                2'b01:   count <= count - WB_CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage.
    always_ff @(posedge Clk) begin
        // NOTE: the storage array has no reset; slot contents are only
        // observed through entry_valid/count, which are reset.
        if (push_en) mem[wr_ptr] <= push_entry;
    end

    // A slot is live when its distance from the read pointer is below the occupancy.
    always_comb begin
        // NOTE: combinational outputs get a default first so no path
        // leaves them unassigned and infers a latch.
        entry_valid = '0;
        entry_addr  = '0;
        for (int i = 0; i < WB_FIFO_DEPTH; i++) begin
            entry_valid[i] = (WB_CNT_W'(WB_PTR_W'(WB_PTR_W'(i) - rd_ptr)) < count);
            entry_addr[i]  = mem[i].addr;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-back arbiter.
// Two request ports, each buffered in a wb_fifo2, share one register file
// write port. Round-robin arbitration between non-empty FIFO heads; the
// granted entry is registered onto Write_Reg/W_Addr/W_Data. Q_Hit reports
// whether a queried register has a write still pending.
// Optional feature: define RF_ZERO_GUARD_EN to suppress writes to
// register 0 (entries are still consumed) and exclude it from Q_Hit.
module regfile_wb_arbiter import rf_wb_pkg::*; (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 Req_Valid_0,
    output logic                 Req_Ready_0,
    input  logic [RF_ADDR_W-1:0] Req_Addr_0,
    input  logic [RF_DATA_W-1:0] Req_Data_0,
    input  logic                 Req_Valid_1,
    output logic                 Req_Ready_1,
    input  logic [RF_ADDR_W-1:0] Req_Addr_1,
    input  logic [RF_DATA_W-1:0] Req_Data_1,
    output logic                 Write_Reg,
    output logic [RF_ADDR_W-1:0] W_Addr,
    output logic [RF_DATA_W-1:0] W_Data,
    input  logic [RF_ADDR_W-1:0] Q_Addr,
    output logic                 Q_Hit,
    output logic                 Busy
);

`ifdef RF_ZERO_GUARD_EN
    localparam bit ZERO_GUARD = 1'b1;
`else
    localparam bit ZERO_GUARD = 1'b0;
`endif

    logic      [WB_PORTS-1:0] req_valid;
    logic      [WB_PORTS-1:0] push;
    logic      [WB_PORTS-1:0] pop;
    logic      [WB_PORTS-1:0] full;
    logic      [WB_PORTS-1:0] empty;
    wb_entry_t                req_entry   [WB_PORTS];
    wb_entry_t                head        [WB_PORTS];
    logic      [WB_FIFO_DEPTH-1:0] fifo_valid [WB_PORTS];
    rf_addr_t  [WB_FIFO_DEPTH-1:0] fifo_addr  [WB_PORTS];

    port_e     last_grant;
    port_e     last_grant_nxt;
    logic      grant_any;
    logic      write_en;
    wb_entry_t granted;

    // Port bundling; ready comes straight from registered FIFO occupancy.
    assign req_valid    = {Req_Valid_1, Req_Valid_0};
    assign req_entry[0] = '{addr: Req_Addr_0, data: Req_Data_0};
    assign req_entry[1] = '{addr: Req_Addr_1, data: Req_Data_1};
    assign Req_Ready_0  = !full[0];
    assign Req_Ready_1  = !full[1];
    assign push         = req_valid & ~full;

    for (genvar p = 0; p < WB_PORTS; p++) begin : g_port
        wb_fifo2 u_fifo (
            .Clk         (Clk),
            .Reset       (Reset),
            .push        (push[p]),
            .push_entry  (req_entry[p]),
            .pop         (pop[p]),
            .full        (full[p]),
            .empty       (empty[p]),
            .head        (head[p]),
            .entry_valid (fifo_valid[p]),
            .entry_addr  (fifo_addr[p])
        );
    end

    // Last-grant pointer; reset to PORT1 so port 0 wins the first contention.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) last_grant <= PORT1;
        else       last_grant <= last_grant_nxt;
    end

    // Round-robin grant: a sole non-empty port wins, otherwise the port not granted last.
    always_comb begin
        pop            = '0;
        last_grant_nxt = last_grant;
        if (!empty[0] && (empty[1] || last_grant == PORT1)) begin
            pop[0]         = 1'b1;
            last_grant_nxt = PORT0;
        end else if (!empty[1]) begin
            pop[1]         = 1'b1;
            last_grant_nxt = PORT1;
        end
    end

    assign grant_any = |pop;
    assign granted   = pop[1] ? head[1] : head[0];
    assign write_en  = grant_any && !(ZERO_GUARD && (granted.addr == '0));

    // Output stage: registers the granted entry; Write_Reg drops in idle cycles.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            Write_Reg <= 1'b0;
            W_Addr    <= '0;
            W_Data    <= '0;
        end else begin
            Write_Reg <= write_en;
            if (grant_any) begin
                W_Addr <= granted.addr;
                W_Data <= granted.data;
            end
        end
    end

    // Hazard query across every live FIFO slot and the output stage.
    always_comb begin
        Q_Hit = addr_match(Write_Reg, W_Addr, Q_Addr);
        for (int p = 0; p < WB_PORTS; p++) begin
            for (int i = 0; i < WB_FIFO_DEPTH; i++) begin
                if (addr_match(fifo_valid[p][i], fifo_addr[p][i], Q_Addr)) Q_Hit = 1'b1;
            end
        end
        if (ZERO_GUARD && (Q_Addr == '0)) Q_Hit = 1'b0;
    end

    assign Busy = !empty[0] || !empty[1] || Write_Reg;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: a table of single-cycle
// vectors plus hand-written sequences for contention, back-pressure and
// mid-operation reset.
module tb_regfile_wb_arbiter;

`ifdef RF_ZERO_GUARD_EN
    localparam bit ZG = 1'b1;
`else
    localparam bit ZG = 1'b0;
`endif

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Req_Valid_0, Req_Valid_1;
    logic        Req_Ready_0, Req_Ready_1;
    logic [4:0]  Req_Addr_0, Req_Addr_1;
    logic [31:0] Req_Data_0, Req_Data_1;
    logic        Write_Reg;
    logic [4:0]  W_Addr;
    logic [31:0] W_Data;
    logic [4:0]  Q_Addr;
    logic        Q_Hit;
    logic        Busy;

    int n_cmp  = 0;
    int n_fail = 0;

    regfile_wb_arbiter dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Req_Valid_0 (Req_Valid_0),
        .Req_Ready_0 (Req_Ready_0),
        .Req_Addr_0  (Req_Addr_0),
        .Req_Data_0  (Req_Data_0),
        .Req_Valid_1 (Req_Valid_1),
        .Req_Ready_1 (Req_Ready_1),
        .Req_Addr_1  (Req_Addr_1),
        .Req_Data_1  (Req_Data_1),
        .Write_Reg   (Write_Reg),
        .W_Addr      (W_Addr),
        .W_Data      (W_Data),
        .Q_Addr      (Q_Addr),
        .Q_Hit       (Q_Hit),
        .Busy        (Busy)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic        v0;
        logic [4:0]  a0;
        logic [31:0] d0;
        logic        v1;
        logic [4:0]  a1;
        logic [31:0] d1;
        logic [4:0]  q;
        logic        e_rdy0;
        logic        e_rdy1;
        logic        e_wr;
        logic [4:0]  e_waddr;
        logic [31:0] e_wdata;
        logic        e_qhit;
        logic        e_busy;
    } vec_t;

    localparam int NVEC = 17;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        Req_Valid_0 = 1'b0; Req_Addr_0 = '0; Req_Data_0 = '0;
        Req_Valid_1 = 1'b0; Req_Addr_1 = '0; Req_Data_1 = '0;
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    int n0, n1;
    logic acc0, acc1;

    initial begin
        // Inputs applied before an edge; expected outputs just after it.
        //           v0 a0  d0            v1 a1  d1     q   rdy0 rdy1 wr  waddr wdata         qhit busy
        vecs[0]  = '{1, 3, 32'hDEADBEEF, 0, 0, 32'h0, 3,  1,   1,   0,  0,    32'h0,        1,   1};
        vecs[1]  = '{0, 0, 32'h0,        0, 0, 32'h0, 3,  1,   1,   1,  3,    32'hDEADBEEF, 1,   1};
        vecs[2]  = '{0, 0, 32'h0,        0, 0, 32'h0, 3,  1,   1,   0,  0,    32'h0,        0,   0};
        vecs[3]  = '{0, 0, 32'h0,        1, 7, 32'h77,7,  1,   1,   0,  0,    32'h0,        1,   1};
        vecs[4]  = '{0, 0, 32'h0,        0, 0, 32'h0, 7,  1,   1,   1,  7,    32'h77,       1,   1};
        vecs[5]  = '{0, 0, 32'h0,        0, 0, 32'h0, 7,  1,   1,   0,  0,    32'h0,        0,   0};
        vecs[6]  = '{1, 0, 32'h1,        0, 0, 32'h0, 0,  1,   1,   0,  0,    32'h0,        !ZG, 1};
        vecs[7]  = '{0, 0, 32'h0,        0, 0, 32'h0, 0,  1,   1,   !ZG,0,    32'h1,        !ZG, !ZG};
        vecs[8]  = '{0, 0, 32'h0,        0, 0, 32'h0, 0,  1,   1,   0,  0,    32'h0,        0,   0};
        vecs[9]  = '{1, 4, 32'h44,       1, 5, 32'h55,5,  1,   1,   0,  0,    32'h0,        1,   1};
        vecs[10] = '{0, 0, 32'h0,        0, 0, 32'h0, 4,  1,   1,   1,  5,    32'h55,       1,   1};
        vecs[11] = '{0, 0, 32'h0,        0, 0, 32'h0, 5,  1,   1,   1,  4,    32'h44,       0,   1};
        vecs[12] = '{0, 0, 32'h0,        0, 0, 32'h0, 5,  1,   1,   0,  0,    32'h0,        0,   0};
        vecs[13] = '{1, 9, 32'h90,       0, 0, 32'h0, 10, 1,   1,   0,  0,    32'h0,        0,   1};
        vecs[14] = '{1, 10,32'hA,        0, 0, 32'h0, 10, 1,   1,   1,  9,    32'h90,       1,   1};
        vecs[15] = '{0, 0, 32'h0,        0, 0, 32'h0, 10, 1,   1,   1,  10,   32'hA,        1,   1};
        vecs[16] = '{0, 0, 32'h0,        0, 0, 32'h0, 10, 1,   1,   0,  0,    32'h0,        0,   0};

        // Reset state
        Reset = 1'b1;
        idle_inputs();
        Q_Addr = 5'd0;
        #2;
        check("reset Req_Ready_0", Req_Ready_0, 1);
        check("reset Req_Ready_1", Req_Ready_1, 1);
        check("reset Write_Reg",   Write_Reg,   0);
        check("reset W_Addr",      W_Addr,      0);
        check("reset W_Data",      W_Data,      0);
        check("reset Q_Hit",       Q_Hit,       0);
        check("reset Busy",        Busy,        0);
        @(negedge Clk);
        Reset = 1'b0;

        // Table-driven vectors
        for (int i = 0; i < NVEC; i++) begin
            Req_Valid_0 = vecs[i].v0; Req_Addr_0 = vecs[i].a0; Req_Data_0 = vecs[i].d0;
            Req_Valid_1 = vecs[i].v1; Req_Addr_1 = vecs[i].a1; Req_Data_1 = vecs[i].d1;
            Q_Addr      = vecs[i].q;
            tick();
            check($sformatf("vec%0d Req_Ready_0", i), Req_Ready_0, vecs[i].e_rdy0);
            check($sformatf("vec%0d Req_Ready_1", i), Req_Ready_1, vecs[i].e_rdy1);
            check($sformatf("vec%0d Write_Reg", i),   Write_Reg,   vecs[i].e_wr);
            check($sformatf("vec%0d Q_Hit", i),       Q_Hit,       vecs[i].e_qhit);
            check($sformatf("vec%0d Busy", i),        Busy,        vecs[i].e_busy);
            if (vecs[i].e_wr) begin
                check($sformatf("vec%0d W_Addr", i), W_Addr, vecs[i].e_waddr);
                check($sformatf("vec%0d W_Data", i), W_Data, vecs[i].e_wdata);
            end
        end
        idle_inputs();

        // Both ports valid every cycle from reset: alternating writes, port 1 back-pressure
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        n0 = 0;
        n1 = 0;
        Q_Addr = 5'd1;
        for (int c = 1; c <= 12; c++) begin
            Req_Valid_0 = 1'b1; Req_Addr_0 = 5'd1; Req_Data_0 = 32'hA000_0000 + n0;
            Req_Valid_1 = 1'b1; Req_Addr_1 = 5'd2; Req_Data_1 = 32'hB000_0000 + n1;
            acc0 = Req_Ready_0;
            acc1 = Req_Ready_1;
            tick();
            if (acc0) n0++;
            if (acc1) n1++;
            if (c == 1) begin
                check("rr c1 Write_Reg", Write_Reg, 0);
            end else begin
                check($sformatf("rr c%0d Write_Reg", c), Write_Reg, 1);
                if (c % 2 == 0) begin
                    check($sformatf("rr c%0d W_Addr", c), W_Addr, 5'd1);
                    check($sformatf("rr c%0d W_Data", c), W_Data, 32'hA000_0000 + (c - 2) / 2);
                end else begin
                    check($sformatf("rr c%0d W_Addr", c), W_Addr, 5'd2);
                    check($sformatf("rr c%0d W_Data", c), W_Data, 32'hB000_0000 + (c - 3) / 2);
                end
            end
            if (c == 2) begin
                check("bp Req_Ready_1 after 2 accepts", Req_Ready_1, 0);
                check("bp port1 accepts after edge 2", n1, 2);
            end
            if (c == 3) begin
                check("bp Req_Ready_1 after pop", Req_Ready_1, 1);
                check("bp port1 3rd held while full", n1, 2);
            end
            if (c == 4) check("bp port1 3rd accepted after pop", n1, 3);
            check($sformatf("rr c%0d Busy", c), Busy, 1);
        end

        // Mid-operation reset with entries pending
        #2;
        Reset = 1'b1;
        #1;
        check("midrst Busy",        Busy,        0);
        check("midrst Write_Reg",   Write_Reg,   0);
        check("midrst W_Data",      W_Data,      0);
        check("midrst Q_Hit",       Q_Hit,       0);
        check("midrst Req_Ready_0", Req_Ready_0, 1);
        check("midrst Req_Ready_1", Req_Ready_1, 1);
        idle_inputs();
        @(negedge Clk);
        Reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            check($sformatf("postrst c%0d Write_Reg", c), Write_Reg, 0);
            check($sformatf("postrst c%0d Busy", c),      Busy,      0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
